// File: rtl/dwt_pkg.sv
// Shared types for the DWT split controller.
//   DWT_DATA_W : default sample width
//   wr_state_t : write (split) FSM states
//   rd_state_t : read (pair issue) FSM states
//   pair_t     : one (even, odd, last) output pair at the default width
package dwt_pkg;

    localparam int DWT_DATA_W = 16;

    typedef enum logic [1:0] {
        S_EVEN  = 2'd0,
        S_ODD   = 2'd1,
        S_PAD   = 2'd2,
        S_DRAIN = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_HOLD  = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [DWT_DATA_W-1:0] even;
        logic [DWT_DATA_W-1:0] odd;
        logic                  last;
    } pair_t;

endpackage

// File: rtl/dwt_pair_reg.sv
// Output holding register for one pair with valid/ready semantics.
// A load captures pair_in and raises valid; valid drops on a handshake
// (valid & ready) that is not accompanied by a new load. The payload is
// stable whenever valid is high and ready is low.
// Ports:
//   clk, reset (async, active-high)
//   load, pair_in    : capture request and payload
//   ready            : downstream accept
//   valid, pair_out  : held pair
import dwt_pkg::*;

module dwt_pair_reg #(
    parameter type pair_type = pair_t
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  pair_type pair_in,
    input  logic     ready,
    output logic     valid,
    output pair_type pair_out
);

    logic     valid_q, valid_d;
    pair_type pair_q, pair_d;

    assign valid    = valid_q;
    assign pair_out = pair_q;

    always_comb begin
        valid_d = valid_q;
        pair_d  = pair_q;
        if (load) begin
            valid_d = 1'b1;
            pair_d  = pair_in;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pair_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pair_q  <= pair_d;
        end
    end

endmodule

// File: rtl/fifo.sv
// Small synchronous FIFO used as the even/odd lane buffer.
// Read data is registered: data_out is valid the cycle after rd_en.
// A write and a read in the same cycle are both honoured.
// Ports:
//   clk, reset (async, active-high)
//   wr_en, data_in   : push side
//   rd_en, data_out  : pop side
//   full, empty      : occupancy flags
module fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              do_wr, do_rd;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign data_out = data_out_q;

    always_comb begin
        do_wr      = wr_en & ~full;
        do_rd      = rd_en & ~empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d   = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/dwt_split_ctrl.sv
// Front-end sequencer of the DWT lifting pipeline.
// Splits the input sample stream into even/odd lanes held in two external
// FIFOs, pops both FIFOs in lockstep and issues (even, odd) pairs with a
// frame-end flag. Odd-length frames are closed by copying the last even
// sample into the odd lane.
// Optional feature macro: DWT_SPLIT_STATS_EN adds stall_cnt / frame_cnt.
// Ports:
//   clk, reset (async, active-high, clears everything)
//   in_valid/in_ready/in_data/in_last : sample input stream
//   ev_* / od_*                       : even / odd FIFO control and data
//   pair_valid/pair_ready             : pair output handshake
//   pair_even/pair_odd/pair_last      : pair payload
//   busy                              : frame in progress
//   stall_cnt, frame_cnt              : statistics (DWT_SPLIT_STATS_EN only)
import dwt_pkg::*;

module dwt_split_ctrl #(
    parameter int DATA_W    = DWT_DATA_W,
    parameter int FRAME_MAX = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              ev_wr_en,
    output logic              ev_rd_en,
    output logic [DATA_W-1:0] ev_data_in,
    input  logic [DATA_W-1:0] ev_data_out,
    input  logic              ev_full,
    input  logic              ev_empty,
    output logic              od_wr_en,
    output logic              od_rd_en,
    output logic [DATA_W-1:0] od_data_in,
    input  logic [DATA_W-1:0] od_data_out,
    input  logic              od_full,
    input  logic              od_empty,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [DATA_W-1:0] pair_even,
    output logic [DATA_W-1:0] pair_odd,
    output logic              pair_last,
    output logic              busy
`ifdef DWT_SPLIT_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int PW = $clog2(FRAME_MAX / 2 + 1);
    localparam int SW = $clog2(FRAME_MAX + 1);

    typedef struct packed {
        logic [DATA_W-1:0] even;
        logic [DATA_W-1:0] odd;
        logic              last;
    } pair_w_t;

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [DATA_W-1:0] last_ev_q, last_ev_d;
    logic [PW-1:0]     wr_pairs_q, wr_pairs_d;
    logic [PW-1:0]     rd_pairs_q, rd_pairs_d;
    logic [PW-1:0]     frame_len_q, frame_len_d;
    logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
    logic              run_q;

    logic              accept;
    logic              eff_last;
    logic              both_avail;
    logic              pop;
    logic              load;
    logic              pair_vld;
    logic              last_hs;
    pair_w_t           pair_in;
    pair_w_t           pair_out;

    // A frame that runs to FRAME_MAX samples is closed as if in_last had
    // been seen on its final sample.
    assign eff_last   = in_last | (samp_cnt_q == SW'(FRAME_MAX - 1));
    // run_q keeps the input closed for the first cycle after reset so every
    // output reads 0 while reset is asserted.
    assign both_avail = run_q & ~ev_empty & ~od_empty;
    assign last_hs    = pair_vld & pair_ready & pair_out.last;

    always_comb begin
        wr_state_d  = wr_state_q;
        last_ev_d   = last_ev_q;
        wr_pairs_d  = wr_pairs_q;
        frame_len_d = frame_len_q;
        samp_cnt_d  = samp_cnt_q;
        in_ready    = 1'b0;
        accept      = 1'b0;
        ev_wr_en    = 1'b0;
        od_wr_en    = 1'b0;
        ev_data_in  = '0;
        od_data_in  = '0;
        case (wr_state_q)
            S_EVEN: begin
                in_ready = run_q & ~ev_full;
                accept   = in_valid & in_ready;
                if (accept) begin
                    ev_wr_en   = 1'b1;
                    ev_data_in = in_data;
                    last_ev_d  = in_data;
                    samp_cnt_d = samp_cnt_q + SW'(1);
                    wr_state_d = eff_last ? S_PAD : S_ODD;
                end
            end
            S_ODD: begin
                in_ready = run_q & ~od_full;
                accept   = in_valid & in_ready;
                if (accept) begin
                    od_wr_en   = 1'b1;
                    od_data_in = in_data;
                    wr_pairs_d = wr_pairs_q + PW'(1);
                    samp_cnt_d = samp_cnt_q + SW'(1);
                    if (eff_last) begin
                        frame_len_d = wr_pairs_q + PW'(1);
                        wr_state_d  = S_DRAIN;
                    end else begin
                        wr_state_d  = S_EVEN;
                    end
                end
            end
            S_PAD: begin
                // Symmetric extension: the odd partner of a trailing even
                // sample is the same sample.
                if (!od_full) begin
                    od_wr_en    = 1'b1;
                    od_data_in  = last_ev_q;
                    wr_pairs_d  = wr_pairs_q + PW'(1);
                    frame_len_d = wr_pairs_q + PW'(1);
                    wr_state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_hs) begin
                    wr_pairs_d  = '0;
                    frame_len_d = '0;
                    samp_cnt_d  = '0;
                    wr_state_d  = S_EVEN;
                end
            end
            default: wr_state_d = S_EVEN;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_pairs_d = rd_pairs_q;
        pop        = 1'b0;
        load       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (both_avail) begin
                    pop        = 1'b1;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                load       = 1'b1;
                rd_pairs_d = rd_pairs_q + PW'(1);
                rd_state_d = R_HOLD;
            end
            R_HOLD: begin
                if (pair_vld && pair_ready) begin
                    if (pair_out.last) begin
                        rd_pairs_d = '0;
                    end
                    if (both_avail) begin
                        pop        = 1'b1;
                        rd_state_d = R_FETCH;
                    end else begin
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // The last pair is fetched only after the write side has reached
    // S_DRAIN, so the frame-end flag can be decided at capture time.
    always_comb begin
        pair_in.even = ev_data_out;
        pair_in.odd  = od_data_out;
        pair_in.last = (wr_state_q == S_DRAIN) &&
                       ((rd_pairs_q + PW'(1)) == frame_len_q);
    end

    assign ev_rd_en = pop;
    assign od_rd_en = pop;

    dwt_pair_reg #(
        .pair_type(pair_w_t)
    ) u_pair_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .pair_in  (pair_in),
        .ready    (pair_ready),
        .valid    (pair_vld),
        .pair_out (pair_out)
    );

    assign pair_valid = pair_vld;
    assign pair_even  = pair_out.even;
    assign pair_odd   = pair_out.odd;
    assign pair_last  = pair_vld & pair_out.last;
    assign busy       = (wr_state_q != S_EVEN) | (rd_pairs_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state_q  <= S_EVEN;
            rd_state_q  <= R_IDLE;
            last_ev_q   <= '0;
            wr_pairs_q  <= '0;
            rd_pairs_q  <= '0;
            frame_len_q <= '0;
            samp_cnt_q  <= '0;
            run_q       <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            last_ev_q   <= last_ev_d;
            wr_pairs_q  <= wr_pairs_d;
            rd_pairs_q  <= rd_pairs_d;
            frame_len_q <= frame_len_d;
            samp_cnt_q  <= samp_cnt_d;
            run_q       <= 1'b1;
        end
    end

`ifdef DWT_SPLIT_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Both counters saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (last_hs && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_dwt_split_ctrl.sv
// Bench for dwt_split_ctrl with two depth-2 FIFOs. Expected pairs are derived
// from each frame's sample list (chunked at FRAME_MAX, paired, odd tail
// duplicated) and queued; a monitor pops and compares on every handshake.
module tb_dwt_split_ctrl;

    localparam int DW   = 16;
    localparam int FMAX = 8;

    typedef struct {
        logic [DW-1:0] e;
        logic [DW-1:0] o;
        logic          last;
    } exp_t;

    logic          clk, reset;
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          ev_wr_en, ev_rd_en, ev_full, ev_empty;
    logic [DW-1:0] ev_data_in, ev_data_out;
    logic          od_wr_en, od_rd_en, od_full, od_empty;
    logic [DW-1:0] od_data_in, od_data_out;
    logic          pair_valid, pair_ready, pair_last, busy;
    logic [DW-1:0] pair_even, pair_odd;
`ifdef DWT_SPLIT_STATS_EN
    logic [31:0]   stall_cnt;
    logic [15:0]   frame_cnt;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   viol       = 0;
    int   stall_model = 0;
    int   frames_done = 0;
    int   pr_mode    = 1;
    bit   chk_busy_next = 0;
    exp_t sbq[$];

    fifo #(.DATA_W(DW), .DEPTH(2)) u_ev (
        .clk(clk), .reset(reset), .wr_en(ev_wr_en), .rd_en(ev_rd_en),
        .data_in(ev_data_in), .data_out(ev_data_out), .full(ev_full), .empty(ev_empty));

    fifo #(.DATA_W(DW), .DEPTH(2)) u_od (
        .clk(clk), .reset(reset), .wr_en(od_wr_en), .rd_en(od_rd_en),
        .data_in(od_data_in), .data_out(od_data_out), .full(od_full), .empty(od_empty));

    dwt_split_ctrl #(.DATA_W(DW), .FRAME_MAX(FMAX)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .ev_wr_en(ev_wr_en), .ev_rd_en(ev_rd_en), .ev_data_in(ev_data_in),
        .ev_data_out(ev_data_out), .ev_full(ev_full), .ev_empty(ev_empty),
        .od_wr_en(od_wr_en), .od_rd_en(od_rd_en), .od_data_in(od_data_in),
        .od_data_out(od_data_out), .od_full(od_full), .od_empty(od_empty),
        .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_even(pair_even),
        .pair_odd(pair_odd), .pair_last(pair_last), .busy(busy)
`ifdef DWT_SPLIT_STATS_EN
        , .stall_cnt(stall_cnt), .frame_cnt(frame_cnt)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a stream is cut into frames of at most FMAX samples; each
    // frame yields ceil(len/2) pairs (x[2n], x[2n+1]); a missing odd partner
    // is replaced by x[2n]; the final pair of each frame is flagged last.
    function automatic void push_expected(input logic [DW-1:0] s[$]);
        int   base, len, np;
        exp_t x;
        base = 0;
        while (base < s.size()) begin
            len = s.size() - base;
            if (len > FMAX) len = FMAX;
            np = (len + 1) / 2;
            for (int n = 0; n < np; n++) begin
                x.e    = s[base + 2*n];
                x.o    = (2*n + 1 < len) ? s[base + 2*n + 1] : s[base + 2*n];
                x.last = (n == np - 1);
                sbq.push_back(x);
            end
            base += len;
        end
    endfunction

    // pair_ready changes just after the rising edge only.
    always begin
        @(posedge clk);
        #1;
        case (pr_mode)
            0:       pair_ready = 1'b0;
            1:       pair_ready = 1'b1;
            default: pair_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: everything is sampled on the falling edge.
    always begin
        exp_t x;
        @(negedge clk);
        if (!reset) begin
            if (ev_wr_en && ev_full) viol++;
            if (od_wr_en && od_full) viol++;
            if (ev_rd_en !== od_rd_en) viol++;
            if (ev_rd_en && (ev_empty || od_empty)) viol++;
            if (in_valid && !in_ready) stall_model++;
            if (chk_busy_next) begin
                check("busy_after_last", {31'd0, busy}, 32'd0);
                chk_busy_next = 0;
            end
            if (pair_valid && pair_ready) begin
                if (sbq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pair_unexpected actual=%h/%h required=none", pair_even, pair_odd);
                end else begin
                    x = sbq.pop_front();
                    check("pair_even", {16'd0, pair_even}, {16'd0, x.e});
                    check("pair_odd",  {16'd0, pair_odd},  {16'd0, x.o});
                    check("pair_last", {31'd0, pair_last}, {31'd0, x.last});
                    if (x.last) begin
                        check("busy_on_last", {31'd0, busy}, 32'd1);
                        chk_busy_next = 1;
                        frames_done++;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_sample(input logic [DW-1:0] d, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL in_accept_timeout actual=stalled required=accepted data=%h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] s[$], input int gap_max);
        push_expected(s);
        for (int i = 0; i < s.size(); i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sample(s[i], (i == s.size() - 1));
        end
        @(negedge clk);
        check("in_ready_after_last", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || pair_valid) && guard < 400) begin
            guard++;
            @(posedge clk);
            #1;
        end
        check("drain_pending", sbq.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [DW-1:0] fq[$];
        int stall_before;
        int nlen;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        pr_mode  = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   {31'd0, in_ready},   32'd0);
        check("rst_pair_valid", {31'd0, pair_valid}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_wr_en",      {30'd0, ev_wr_en, od_wr_en}, 32'd0);
        check("rst_rd_en",      {30'd0, ev_rd_en, od_rd_en}, 32'd0);
        check("rst_pair_data",  {pair_even, pair_odd}, 32'd0);
        check("rst_pair_last",  {31'd0, pair_last},  32'd0);
        reset = 1'b0;

        // Even-length frame.
        fq = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        send_frame(fq, 0);
        wait_drain();

        // Odd-length frame closed by symmetric extension.
        fq = {16'h0005, 16'h0006, 16'h0007};
        send_frame(fq, 0);
        wait_drain();

        // Downstream stalled while 8 samples stream in.
        pr_mode = 0;
        stall_before = stall_model;
        fq = {16'h0101, 16'h0202, 16'h0303, 16'h0404,
              16'h0505, 16'h0606, 16'h0707, 16'h0808};
        fork
            send_frame(fq, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("backpressure_stall_seen", {31'd0, (stall_model > stall_before)}, 32'd1);
                pr_mode = 1;
            end
        join
        wait_drain();
`ifdef DWT_SPLIT_STATS_EN
        check("stall_cnt_bp", stall_cnt, stall_model);
`endif

        // Single-sample frame.
        fq = {16'h00AA};
        send_frame(fq, 0);
        wait_drain();

        // Reset in the middle of a frame.
        pr_mode = 0;
        send_sample(16'h0E01, 1'b0);
        send_sample(16'h0E02, 1'b0);
        send_sample(16'h0E03, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pair_held_before_reset", {31'd0, pair_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_pair_valid", {31'd0, pair_valid}, 32'd0);
        check("midrst_in_ready",   {31'd0, in_ready},   32'd0);
        check("midrst_busy",       {31'd0, busy},       32'd0);
        sbq.delete();
        stall_model   = 0;
        frames_done   = 0;
        chk_busy_next = 0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        pr_mode = 1;
        fq = {16'h0001, 16'h0002};
        send_frame(fq, 0);
        wait_drain();

        // Stream longer than FRAME_MAX with in_last only on the final sample.
        pr_mode = 2;
        fq = {};
        for (int i = 0; i < FMAX + 3; i++) fq.push_back(16'($urandom));
        send_frame(fq, 1);
        wait_drain();

        // Random frames, random gaps, random downstream readiness.
        for (int f = 0; f < 10; f++) begin
            fq = {};
            nlen = $urandom_range(1, FMAX);
            for (int i = 0; i < nlen; i++) fq.push_back(16'($urandom));
            send_frame(fq, 2);
        end
        wait_drain();

        check("protocol_violations", viol, 0);
`ifdef DWT_SPLIT_STATS_EN
        check("stall_cnt_final", stall_cnt, stall_model);
        check("frame_cnt_final", {16'd0, frame_cnt}, frames_done);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
